// File: rtl/kombajn_pkg.sv
// rtl/kombajn_pkg.sv - shared constants and FSM state type for the key search datapath
package kombajn_pkg;

  localparam int KEY_W    = 128;
  localparam int STRIDE_W = 8;

  // Plaintext the downstream comparator looks for after decoding a candidate key.
  localparam logic [63:0] KNOWN_PT = 64'h4B4F_4D42_414A_4E21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } kr_state_e;

endpackage

// File: rtl/key_step.sv
// rtl/key_step.sv - next candidate key and end-of-range detection
module key_step #(
  parameter int KEY_W    = 128,
  parameter int STRIDE_W = 8
) (
  input  logic [KEY_W-1:0]    key,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [KEY_W-1:0]    limit,
  output logic [KEY_W-1:0]    nxt,
  output logic                last
);

  logic [STRIDE_W-1:0] stride_eff;
  logic [KEY_W:0]      sum;

  // A zero stride would stall the sweep forever, so it steps by one instead.
  assign stride_eff = (stride == '0) ? STRIDE_W'(1) : stride;
  assign sum        = {1'b0, key} + {{(KEY_W + 1 - STRIDE_W){1'b0}}, stride_eff};
  assign nxt        = sum[KEY_W-1:0];
  assign last       = sum[KEY_W] | (sum[KEY_W-1:0] > limit);

endmodule

// File: rtl/key_range_gen.sv
// rtl/key_range_gen.sv - strided key sweep source; KEYRANGE_PROGRESS_EN adds key_count
module key_range_gen
  import kombajn_pkg::*;
#(
  parameter int KEY_W    = kombajn_pkg::KEY_W,
  parameter int STRIDE_W = kombajn_pkg::STRIDE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [KEY_W-1:0]    key_base,
  input  logic [KEY_W-1:0]    key_limit,
  input  logic [STRIDE_W-1:0] stride,
  output logic [KEY_W-1:0]    key,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                busy,
  output logic                done,
  output logic                exhausted
`ifdef KEYRANGE_PROGRESS_EN
  ,
  output logic [63:0]         key_count
`endif
);

  kr_state_e           state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [KEY_W-1:0]    limit_q, limit_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic                exh_q, exh_d;
  logic [KEY_W-1:0]    nxt;
  logic                last;
  logic                xfer;
  logic                start_ok;

  key_step #(
    .KEY_W   (KEY_W),
    .STRIDE_W(STRIDE_W)
  ) u_key_step (
    .key   (key_q),
    .stride(stride_q),
    .limit (limit_q),
    .nxt   (nxt),
    .last  (last)
  );

  // Being in RUN is exactly the condition under which a key is on offer.
  assign xfer     = (state_q == ST_RUN) && key_ready;
  assign start_ok = start && (state_q != ST_RUN);

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    limit_d  = limit_q;
    stride_d = stride_q;
    exh_d    = exh_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          key_d    = key_base;
          limit_d  = key_limit;
          stride_d = stride;
          if (key_base > key_limit) begin
            state_d = ST_DONE;
            exh_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            exh_d   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        // A hit freezes the key even when that same key was just handed over.
        if (stop) begin
          state_d = ST_DONE;
          exh_d   = 1'b0;
        end else if (xfer) begin
          if (last) begin
            state_d = ST_DONE;
            exh_d   = 1'b1;
          end else begin
            key_d = nxt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      limit_q  <= '0;
      stride_q <= '0;
      exh_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      limit_q  <= limit_d;
      stride_q <= stride_d;
      exh_q    <= exh_d;
    end
  end

  assign key       = key_q;
  assign key_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign exhausted = exh_q;

`ifdef KEYRANGE_PROGRESS_EN
  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_ok) begin
      count_d = '0;
    end else if (xfer && (count_q != '1)) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign key_count = count_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_key_range_gen.sv
// tb/tb_key_range_gen.sv - randomized and directed checks of key_range_gen against a sweep model
module tb_key_range_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [127:0] key_base = '0;
  logic [127:0] key_limit = '0;
  logic [7:0]   stride = '0;
  logic [127:0] key;
  logic         key_valid;
  logic         key_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         exhausted;
`ifdef KEYRANGE_PROGRESS_EN
  logic [63:0]  key_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] all_ones = {128{1'b1}};

  key_range_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .key_base (key_base),
    .key_limit(key_limit),
    .stride   (stride),
    .key      (key),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .busy     (busy),
    .done     (done),
    .exhausted(exhausted)
`ifdef KEYRANGE_PROGRESS_EN
    ,
    .key_count(key_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 ready always high, 1 ready toggles 1/0, 2 random ready.
  // stop_idx: index of the expected key during whose transfer stop is raised (-1 = never).
  task automatic sweep(input string tag, input logic [127:0] base, input logic [127:0] limit,
                       input logic [7:0] strd, input int rmode, input int stop_idx);
    logic [128:0] k;
    logic [128:0] inc;
    int n, idx, cyc;
    bit stopped;
    logic r;
    exp_q.delete();
    inc = (strd == 8'd0) ? 129'd1 : {121'd0, strd};
    k = {1'b0, base};
    while (k[128] == 1'b0 && k[127:0] <= limit) begin
      exp_q.push_back(k[127:0]);
      k = k + inc;
    end
    start = 1'b1;
    key_base = base;
    key_limit = limit;
    stride = strd;
    step();
    start = 1'b0;
    stop = 1'b0;
    key_base = {$urandom, $urandom, $urandom, $urandom};
    key_limit = {$urandom, $urandom, $urandom, $urandom};
    stride = 8'($urandom);
    n = exp_q.size();
    idx = 0;
    cyc = 0;
    stopped = 1'b0;
    if (n == 0) begin
      chk({tag, ".empty_valid"}, key_valid, 1'b0);
      chk({tag, ".empty_done"}, done, 1'b1);
      chk({tag, ".empty_exh"}, exhausted, 1'b1);
    end else begin
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".done_low"}, done, 1'b0);
      while (idx < n && !stopped && cyc < 2000) begin
        if (rmode == 0) r = 1'b1;
        else if (rmode == 1) r = (cyc % 2 == 0);
        else r = 1'($urandom_range(0, 1));
        if (idx == stop_idx) r = 1'b1;
        chk({tag, ".valid"}, key_valid, 1'b1);
        chk({tag, ".key"}, key, exp_q[idx]);
        key_ready = r;
        if (idx == stop_idx) begin
          stop = 1'b1;
          stopped = 1'b1;
        end
        if (r) idx++;
        step();
        stop = 1'b0;
        cyc++;
      end
      if (cyc >= 2000) chk({tag, ".timeout"}, 1'b1, 1'b0);
      key_ready = 1'b0;
      chk({tag, ".end_valid"}, key_valid, 1'b0);
      chk({tag, ".end_busy"}, busy, 1'b0);
      chk({tag, ".end_done"}, done, 1'b1);
      chk({tag, ".end_exh"}, exhausted, stopped ? 1'b0 : 1'b1);
      chk({tag, ".end_key"}, key, exp_q[idx-1]);
    end
`ifdef KEYRANGE_PROGRESS_EN
    chk({tag, ".count"}, key_count, 128'(idx));
`endif
  endtask

  initial begin
    logic [127:0] b, e;
    int si;

    step();
    step();
    chk("rst.key", key, 128'd0);
    chk("rst.valid", key_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.exh", exhausted, 1'b0);
`ifdef KEYRANGE_PROGRESS_EN
    chk("rst.count", key_count, 128'd0);
`endif
    rst = 1'b1;
    step();
    chk("idle.done", done, 1'b0);

    sweep("t1", 128'd5, 128'd8, 8'd1, 0, -1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("done_stop.done", done, 1'b1);
    chk("done_stop.exh", exhausted, 1'b1);

    sweep("t2", 128'd0, 128'd10, 8'd3, 1, -1);
    sweep("t3", all_ones - 128'd1, all_ones, 8'd4, 0, -1);
    sweep("t3b", all_ones - 128'd2, all_ones, 8'd1, 2, -1);
    sweep("t4", 128'd100, 128'd200, 8'd1, 0, 3);
    stop = 1'b1;
    sweep("t4b", 128'd0, 128'd0, 8'd1, 0, -1);
    sweep("t5", 128'd9, 128'd4, 8'd1, 0, -1);
    sweep("t5b", 128'd20, 128'd25, 8'd0, 2, -1);

    for (int i = 0; i < 6; i++) begin
      b = {1'b0, 31'($urandom), $urandom, $urandom, $urandom};
      e = b + 128'($urandom_range(0, 30));
      si = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
      sweep($sformatf("rnd%0d", i), b, e, 8'($urandom_range(0, 6)), 2, si);
    end

    start = 1'b1;
    key_base = 128'd40;
    key_limit = 128'd1000;
    stride = 8'd1;
    key_ready = 1'b1;
    step();
    start = 1'b0;
    e = 128'd40;
    for (int c = 0; c < 30; c++) begin
      chk("t6.key", key, e);
      if (e == 128'd45) begin
        start = 1'b1;
        key_base = 128'd7;
      end
      if (e == 128'd50) break;
      step();
      start = 1'b0;
      e = e + 128'd1;
    end
    rst = 1'b0;
    #1;
    chk("t6.rst_key", key, 128'd0);
    chk("t6.rst_valid", key_valid, 1'b0);
    chk("t6.rst_busy", busy, 1'b0);
    chk("t6.rst_done", done, 1'b0);
    chk("t6.rst_exh", exhausted, 1'b0);
`ifdef KEYRANGE_PROGRESS_EN
    chk("t6.rst_count", key_count, 128'd0);
`endif
    step();
    step();
    chk("t6.held_valid", key_valid, 1'b0);
    rst = 1'b1;
    key_ready = 1'b0;
    step();
    chk("t6.post_idle", busy, 1'b0);
    sweep("t6b", 128'd3, 128'd12, 8'd2, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
